// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a miss, stalls the pipeline and fills one block from pipelined memory.
// Define CACHE_FILL_CWF_EN for critical-word-first issue/fill ordering (default: word 0 first).
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data_out,
  output logic                           fsm_busy,
  output logic                           mem_read,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data
);

  localparam int LW = $clog2(BLOCK_WORDS);
  localparam int CW = LW + 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     issue_cnt, ret_cnt;
  logic [LW-1:0]     issue_word, ret_word;
  logic              last_ret;
  logic              unused_addr_bits;

  // Low address bits only feed the optional word rotation.
  assign unused_addr_bits = ^miss_address[LW:0];
  assign last_ret = memory_data_valid && (ret_cnt == CW'(BLOCK_WORDS - 1));

`ifdef CACHE_FILL_CWF_EN
  logic [LW-1:0] w0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               w0 <= '0;
    else if (state == IDLE && miss_detected)  w0 <= miss_address[LW:1];
  end

  assign issue_word = w0 + issue_cnt[LW-1:0];
  assign ret_word   = w0 + ret_cnt[LW-1:0];
`else
  assign issue_word = issue_cnt[LW-1:0];
  assign ret_word   = ret_cnt[LW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        base      <= {miss_address[ADDR_W-1:LW+1], {(LW+1){1'b0}}};
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end
    end else begin
      if (mem_read)          issue_cnt <= issue_cnt + 1'b1;
      if (memory_data_valid) ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_detected) state_nxt = FILL;
      FILL:    if (last_ret)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    fill_data        = rst_n ? memory_data_out : 16'h0;
    case (state)
      // Stall in the miss cycle itself; held low while reset is asserted.
      IDLE: fsm_busy = miss_detected & rst_n;
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < CW'(BLOCK_WORDS)) begin
          mem_read       = 1'b1;
          memory_address = base | {{(ADDR_W-LW-1){1'b0}}, issue_word, 1'b0};
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = ret_word;
          write_tag_array  = last_ret;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler between the pipelined CPU's cache arrays and the shared multi-cycle main memory.
- On a cache miss it stalls the pipeline and fetches one 16-byte block (8 x 16-bit words) from memory.
- Memory is pipelined and accepts one read per cycle.
- Each returned word is written into the cache data array; the tag array is updated on the final word, after which the stall is released.
- One instance serves the I-cache and one serves the D-cache; an external arbiter selects which instance owns memory.

Parameters:
- BLOCK_WORDS, 8, words per cache block; must be a power of two; address offset width = log2(BLOCK_WORDS)+1 bits.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  16  byte address of the missing access.
- memory_data_valid  in  1  memory returns a word this cycle.
- memory_data_out  in  16  word returned by memory.
- fsm_busy  out  1  stall request to the pipeline.
- mem_read  out  1  memory read request this cycle.
- memory_address  out  16  byte address of the request; meaningful only when mem_read=1.
- write_data_array  out  1  write enable for the cache data array.
- write_tag_array  out  1  write enable for the cache tag array.
- fill_word  out  3  word index within the block for the data-array write.
- fill_data  out  16  data for the data-array write; equals memory_data_out.

Behaviour:
- Reset: asynchronous and active-low; rst_n=0 forces the state to IDLE, clears all counters, and drives every output to 0.
- State IDLE: fsm_busy = miss_detected, combinationally, so the pipeline stalls in the miss cycle itself.
  - On a clock edge with miss_detected=1: latch base = {miss_address[15:4], 4'b0000}, clear issue_cnt and ret_cnt, move to FILL.
- State FILL, issue side: fsm_busy=1.
  - mem_read=1 while issue_cnt < BLOCK_WORDS, with memory_address = base | {issue_cnt, 1'b0}.
  - issue_cnt increments every cycle that mem_read=1.
  - Exactly 8 requests are issued, one per cycle, starting the cycle after the miss.
- State FILL, return side: on each memory_data_valid=1:
  - write_data_array=1, fill_word=ret_cnt[2:0], fill_data=memory_data_out; ret_cnt increments.
- FILL completion: when memory_data_valid=1 and ret_cnt=7:
  - write_tag_array=1 in the same cycle as the last data write; next state is IDLE.
  - fsm_busy falls on the following cycle.
- Latency with 4-cycle memory: last write at miss cycle + 12; fsm_busy low at miss cycle + 13.
- Ignored inputs:
  - memory_data_valid in IDLE: ignored, no writes.
  - miss_detected or miss_address changes during FILL: ignored, since base is already latched.
- Back-to-back misses: a new miss in the first IDLE cycle after completion starts a new fill.
- Reset mid-FILL: abandons the fill with no tag write; the block stays invalid.
- write_data_array, write_tag_array and mem_read are never asserted outside FILL.

Optional Feature:
- Macro: CACHE_FILL_CWF_EN (critical-word-first).
- Defined:
  - Issue order starts at word w0 = miss_address[3:1] and wraps modulo BLOCK_WORDS: w0, w0+1, ..., 7, 0, ..., w0-1.
  - fill_word follows the same rotated order.
  - Completion is still the 8th returned word.
- Undefined: issue order is 0..7 regardless of miss_address.

Test Plan:
- Reset hold: rst_n=0 with miss_detected=1 and memory_data_valid=1 -> all outputs 0; release, no miss -> stays idle, no mem_read.
- Single miss, miss_address=0x1236, 4-cycle memory -> fsm_busy high in miss cycle N; mem_read at N+1..N+8 with addresses 0x1230,0x1232,...,0x123E; data writes at N+5..N+12 with fill_word 0..7; write_tag_array only at N+12; fsm_busy=0 at N+13.
- Jittered memory: gaps inserted between valid pulses -> fill_word increments only on valid; tag write on 8th valid; busy held throughout.
- Disturbance during fill: miss_detected toggled and miss_address=0xFFFE mid-fill -> addresses stay 0x123x; a stray valid in IDLE -> no write.
- Reset mid-fill: rst_n=0 after 3 data writes -> immediate IDLE, no tag write; a fresh miss at 0x0000 refetches 0x0000..0x000E.
- With CACHE_FILL_CWF_EN, miss_address=0x123A -> request order 0x123A,0x123C,0x123E,0x1230,...,0x1238; fill_word 5,6,7,0..4; tag write on the 8th return.
